// File: rtl/mealy_stream_ctrl.sv
// mealy_stream_ctrl
//   Sequencer for a Mealy sequence detector. A WIDTH-bit frame is latched
//   on an accepted start. The detector is then held in reset for one cycle,
//   and the frame is shifted MSB-first into the detector's P1 input, one bit
//   per clock. The block counts the cycles where the detector's z output is
//   high, records the bit index of the first hit, and pulses done at the end
//   of the frame.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   start          begin a frame; sampled only in IDLE (start wins over abort)
//   abort          cancel the frame while in CLEAR/SHIFT
//   frame_in       frame data, latched on the accepted start
//   det_z          detector z output (combinational in P1)
//   det_bit        drives detector P1
//   det_rst        drives detector reset (active-high)
//   busy           high in CLEAR/SHIFT
//   done           one-cycle pulse in DONE
//   hit_count      saturating z count for the last/current frame
//   hit_any        at least one hit seen in the frame
//   first_hit_idx  bit index (0 = MSB) of the first hit, valid when hit_any=1
//   dbg_state      current FSM state (0 IDLE, 1 CLEAR, 2 SHIFT, 3 DONE)
//
// Handshake: start is a request with no ready. It is accepted only on an
// edge where the FSM is in IDLE, and busy rising on the next cycle
// acknowledges it. A start seen in any other state is dropped.
module mealy_stream_ctrl #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] frame_in,
  input  logic             det_z,
  output logic             det_bit,
  output logic             det_rst,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             hit_any,
  output logic [IDX_W-1:0] first_hit_idx,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             any_nxt;
  logic [IDX_W-1:0] first_nxt;
  logic             abort_q, abort_nxt;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      shreg         <= '0;
      idx           <= '0;
      hit_count     <= '0;
      hit_any       <= 1'b0;
      first_hit_idx <= '0;
      abort_q       <= 1'b0;
    end else begin
      state         <= state_nxt;
      shreg         <= shreg_nxt;
      idx           <= idx_nxt;
      hit_count     <= cnt_nxt;
      hit_any       <= any_nxt;
      first_hit_idx <= first_nxt;
      abort_q       <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    cnt_nxt   = hit_count;
    any_nxt   = hit_any;
    first_nxt = first_hit_idx;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt = frame_in;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          any_nxt   = 1'b0;
          first_nxt = '0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          // The z seen on the abort cycle is dropped; partial results hold.
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else begin
          if (det_z) begin
            if (hit_count != CNT_MAX) cnt_nxt = hit_count + 1'b1;
            if (!hit_any) begin
              any_nxt   = 1'b1;
              first_nxt = idx;
            end
          end
          shreg_nxt = shreg << 1;
          idx_nxt   = idx + 1'b1;
          if (idx == LAST_IDX) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The detector is held in reset while our own reset is low, for the CLEAR
  // cycle, and for the cycle after an abort so it never sees a stale prefix.
  assign det_rst   = ~reset | (state == CLEAR) | abort_q;
  assign det_bit   = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
  assign busy      = (state == CLEAR) || (state == SHIFT);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule
